alu_exec_ctrl: RTL and testbench
================================

// Module: alu_exec_ctrl
// PURPOSE
//  Execute-stage sequencer sitting directly upstream of the registered alu.
//  - Accepts one decoded ALU op over a valid/ready handshake.
//  - Reads operands from an internal register file, drives alu a/b/cin,
//    waits out the alu's 1-cycle register latency.
//  - Writes the result back and updates the carry/zero flag register.
//  - Fully serialised: one op every 3 cycles, so no hazards can arise.
// PARAMETERS
//  DATA_BITS      8   datapath width; must equal the alu DATA_BITS
//  REG_COUNT      16  number of general registers
//  REG_ADDR_BITS  4   $clog2(REG_COUNT)
// PORTS
//  clk          in   1              single clock; all state on posedge
//  reset        in   1              synchronous, active-high
//  op_valid     in   1              op fields below are valid
//  op_ready     out  1              ctrl can accept an op this cycle
//  op_sub       in   1              1 = subtract (rA - B), 0 = add
//  op_imm       in   1              1 = B is op_imm_val, 0 = B is rf[op_rb]
//  op_wb_en     in   1              1 = write rf[op_rd]; 0 = flags only (compare)
//  op_rd        in   REG_ADDR_BITS  destination register
//  op_ra        in   REG_ADDR_BITS  source A register
//  op_rb        in   REG_ADDR_BITS  source B register
//  op_imm_val   in   DATA_BITS      immediate operand
//  alu_a        out  DATA_BITS      to alu.a (registered)
//  alu_b        out  DATA_BITS      to alu.b (registered)
//  alu_cin      out  1              to alu.cin (registered); equals op_sub
//  alu_result   in   DATA_BITS      from alu.result
//  alu_cout     in   1              from alu.cout
//  alu_zero     in   1              from alu.zero
//  flag_carry   out  1              carry flag (1 = carry out / no borrow)
//  flag_zero    out  1              zero flag
//  done         out  1              1-cycle pulse: op committed at end of cycle
//  dbg_addr     in   REG_ADDR_BITS  debug register read address
//  dbg_data     out  DATA_BITS      rf[dbg_addr], combinational read
// BEHAVIOUR
//  - Reset, synchronous, wins over everything:
//    - state = S_IDLE; all rf entries = 0.
//    - alu_a, alu_b, alu_cin, flag_carry, flag_zero = 0.
//    - op_ready = 0 while reset is high.
//    - done = 0.
//  - FSM S_IDLE -> S_EXEC -> S_WB -> S_IDLE.
//  - op_ready = (state == S_IDLE) && !reset.
//    - op_valid is ignored in any other state; no op is ever accepted twice.
//  - S_IDLE, on accept (op_valid && op_ready), at the clock edge:
//    - alu_a  <= rf[op_ra]
//    - alu_b  <= op_imm ? op_imm_val : rf[op_rb]
//    - alu_cin <= op_sub
//    - latch op_rd and op_wb_en
//    - go to S_EXEC
//  - S_EXEC: alu captures its operands at the end of this cycle; go to S_WB.
//  - S_WB: alu_result, alu_cout and alu_zero are valid; done = 1.
//    At the clock edge:
//    - flag_carry <= alu_cout; flag_zero <= alu_zero.
//    - if wb_en: rf[rd] <= alu_result.
//    - go to S_IDLE.
//  - Latency: accept edge -> done high 2 cycles later -> rf/flags visible the
//    cycle after done. Ready drops for 2 cycles per op.
//  - alu_a, alu_b, alu_cin hold their last values outside S_IDLE accepts.
//  - Arithmetic is the alu's, modulo 2^DATA_BITS.
//    SUB: cout = 1 iff rA >= B (no borrow).
//  - rd == ra or rd == rb is legal. Operands are captured before the write,
//    so self-update is correct.
//  - Reset in S_EXEC or S_WB aborts the op: no rf write, no flag update,
//    done = 0.
//  - dbg_data is a combinational read; it reflects a write from the cycle
//    after the S_WB edge.
// STRUCTURE
//  - Package exec_pkg holds:
//    - typedef enum logic [1:0] exec_state_t {S_IDLE, S_EXEC, S_WB}
//    - default DATA_BITS / REG_COUNT constants
//  - Sub-module reg_file (REG_COUNT x DATA_BITS):
//    - 2 async read ports plus the dbg read port
//    - 1 sync write port
//    - sync clear on reset
//  - The FSM and operand/flag registers stay in this module.
// TESTING (bench instantiates alu_exec_ctrl + alu, DATA_BITS=8)
//  1. Hold reset 3 cycles, then release
//     -> all outputs 0 throughout reset; op_ready 0 during reset, 1 on the
//        first cycle after release.
//  2. ADDI r1=r0+0x05, then ADD r2=r1+r1
//     -> done 2 cycles after each accept; r2=0x0A, carry=0, zero=0;
//        op_ready low for exactly 2 cycles per op.
//  3. ADDI r3=r0+0xFF, then ADDI r3=r3+0x01
//     -> r3=0x00, carry=1, zero=1 (self-update rd==ra is correct).
//  4. r4=0x03, r5=0x05: SUB r6=r4-r5 -> r6=0xFE, carry=0, zero=0;
//     then SUB r7=r5-r5 -> r7=0x00, carry=1, zero=1.
//  5. Compare (wb_en=0), SUB r5-imm 0x05
//     -> carry=1, zero=1, rd unchanged.
//     Hold op_valid high for 6 cycles -> exactly 2 ops accepted.
//  6. Accept ADDI r8=r0+0x11, assert reset in S_EXEC
//     -> done never pulses; r8=0; flags=0; op_ready=1 the cycle after reset
//        drops.

Source files
------------

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared state encoding and default sizes for the execute stage
package exec_pkg;
   localparam int DEF_DATA_BITS = 8;
   localparam int DEF_REG_COUNT = 16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_WB
   } exec_state_t;
endpackage

// File: rtl/alu.sv
// rtl/alu.sv - registered add/subtract unit with one cycle of latency
module alu
   import exec_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] a,
   input  logic [DATA_BITS-1:0] b,
   input  logic                 cin,
   output logic [DATA_BITS-1:0] result,
   output logic                 cout,
   output logic                 zero
);
   logic [DATA_BITS:0]   sum_d;
   logic [DATA_BITS-1:0] result_q;
   logic                 cout_q;
   logic                 zero_q;

   // cin doubles as the subtract select: a + ~b + 1 when set
   always_comb begin
      sum_d = {1'b0, a} + {1'b0, b ^ {DATA_BITS{cin}}} + {{DATA_BITS{1'b0}}, cin};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result_q <= '0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         result_q <= sum_d[DATA_BITS-1:0];
         cout_q   <= sum_d[DATA_BITS];
         zero_q   <= (sum_d[DATA_BITS-1:0] == '0);
      end
   end

   assign result = result_q;
   assign cout   = cout_q;
   assign zero   = zero_q;
endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - general register file: two async read ports, debug read, one sync write
module reg_file
   import exec_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int REG_COUNT = DEF_REG_COUNT,
   parameter int ADDR_BITS = $clog2(REG_COUNT)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ADDR_BITS-1:0] ra_addr_i,
   output logic [DATA_BITS-1:0] ra_data_o,
   input  logic [ADDR_BITS-1:0] rb_addr_i,
   output logic [DATA_BITS-1:0] rb_data_o,
   input  logic [ADDR_BITS-1:0] dbg_addr_i,
   output logic [DATA_BITS-1:0] dbg_data_o,
   input  logic                 we_i,
   input  logic [ADDR_BITS-1:0] waddr_i,
   input  logic [DATA_BITS-1:0] wdata_i
);
   logic [DATA_BITS-1:0] mem_q [REG_COUNT];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign ra_data_o  = mem_q[ra_addr_i];
   assign rb_data_o  = mem_q[rb_addr_i];
   assign dbg_data_o = mem_q[dbg_addr_i];
endmodule

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - serialised execute sequencer feeding the registered alu
module alu_exec_ctrl
   import exec_pkg::*;
#(
   parameter int DATA_BITS     = DEF_DATA_BITS,
   parameter int REG_COUNT     = DEF_REG_COUNT,
   parameter int REG_ADDR_BITS = $clog2(REG_COUNT)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     op_valid,
   output logic                     op_ready,
   input  logic                     op_sub,
   input  logic                     op_imm,
   input  logic                     op_wb_en,
   input  logic [REG_ADDR_BITS-1:0] op_rd,
   input  logic [REG_ADDR_BITS-1:0] op_ra,
   input  logic [REG_ADDR_BITS-1:0] op_rb,
   input  logic [DATA_BITS-1:0]     op_imm_val,
   output logic [DATA_BITS-1:0]     alu_a,
   output logic [DATA_BITS-1:0]     alu_b,
   output logic                     alu_cin,
   input  logic [DATA_BITS-1:0]     alu_result,
   input  logic                     alu_cout,
   input  logic                     alu_zero,
   output logic                     flag_carry,
   output logic                     flag_zero,
   output logic                     done,
   input  logic [REG_ADDR_BITS-1:0] dbg_addr,
   output logic [DATA_BITS-1:0]     dbg_data
);
   exec_state_t              state_q;
   logic [DATA_BITS-1:0]     alu_a_q;
   logic [DATA_BITS-1:0]     alu_b_q;
   logic                     alu_cin_q;
   logic                     flag_carry_q;
   logic                     flag_zero_q;
   logic [REG_ADDR_BITS-1:0] rd_q;
   logic                     wb_en_q;
   logic [DATA_BITS-1:0]     ra_data;
   logic [DATA_BITS-1:0]     rb_data;
   logic                     rf_we;

   assign rf_we = (state_q == S_WB) && wb_en_q;

   reg_file #(
      .DATA_BITS (DATA_BITS),
      .REG_COUNT (REG_COUNT),
      .ADDR_BITS (REG_ADDR_BITS)
   ) u_reg_file (
      .clk        (clk),
      .reset      (reset),
      .ra_addr_i  (op_ra),
      .ra_data_o  (ra_data),
      .rb_addr_i  (op_rb),
      .rb_data_o  (rb_data),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data),
      .we_i       (rf_we),
      .waddr_i    (rd_q),
      .wdata_i    (alu_result)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_cin_q    <= 1'b0;
         flag_carry_q <= 1'b0;
         flag_zero_q  <= 1'b0;
         rd_q         <= '0;
         wb_en_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (op_valid) begin
                  alu_a_q   <= ra_data;
                  alu_b_q   <= op_imm ? op_imm_val : rb_data;
                  alu_cin_q <= op_sub;
                  rd_q      <= op_rd;
                  wb_en_q   <= op_wb_en;
                  state_q   <= S_EXEC;
               end
            end
            S_EXEC: state_q <= S_WB;
            S_WB: begin
               flag_carry_q <= alu_cout;
               flag_zero_q  <= alu_zero;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // A reset arriving mid-op must suppress both the handshake and the commit pulse
   assign op_ready   = (state_q == S_IDLE) && !reset;
   assign done       = (state_q == S_WB) && !reset;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_cin    = alu_cin_q;
   assign flag_carry = flag_carry_q;
   assign flag_zero  = flag_zero_q;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - scoreboard bench for alu_exec_ctrl with the registered alu
module tb_alu_exec_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       op_valid = 1'b0;
   logic       op_ready;
   logic       op_sub = 1'b0;
   logic       op_imm = 1'b0;
   logic       op_wb_en = 1'b0;
   logic [3:0] op_rd = '0;
   logic [3:0] op_ra = '0;
   logic [3:0] op_rb = '0;
   logic [7:0] op_imm_val = '0;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic       alu_cin;
   logic [7:0] alu_result;
   logic       alu_cout;
   logic       alu_zero;
   logic       flag_carry;
   logic       flag_zero;
   logic       done;
   logic [3:0] dbg_addr = '0;
   logic [7:0] dbg_data;

   typedef struct {
      logic [7:0] res;
      logic       c;
      logic       z;
      logic [3:0] rd;
      logic [7:0] rd_val;
      int         acc;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_exec_ctrl #(.DATA_BITS(8), .REG_COUNT(16), .REG_ADDR_BITS(4)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
      .op_sub(op_sub), .op_imm(op_imm), .op_wb_en(op_wb_en), .op_rd(op_rd),
      .op_ra(op_ra), .op_rb(op_rb), .op_imm_val(op_imm_val),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
      .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero),
      .flag_carry(flag_carry), .flag_zero(flag_zero), .done(done),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   alu #(.DATA_BITS(8)) u_alu (
      .clk(clk), .reset(reset), .a(alu_a), .b(alu_b), .cin(alu_cin),
      .result(alu_result), .cout(alu_cout), .zero(alu_zero)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_op(input logic sub, input logic imm, input logic wb,
                           input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [7:0] iv);
      op_sub = sub; op_imm = imm; op_wb_en = wb;
      op_rd = rd; op_ra = ra; op_rb = rb; op_imm_val = iv;
      op_valid = 1'b1;
   endtask

   task automatic wait_ready(output logic ok);
      int n;
      n = 0;
      while (!op_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      ok = op_ready;
      if (!ok) begin
         check("accept_timeout", 32'(op_ready), 32'd1);
         op_valid = 1'b0;
      end
   endtask

   task automatic issue(input logic sub, input logic imm, input logic wb,
                        input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [7:0] iv, input logic [7:0] er, input logic ec,
                        input logic ez, input logic [7:0] erd);
      logic ok;
      exp_t e;
      @(negedge clk);
      drive_op(sub, imm, wb, rd, ra, rb, iv);
      wait_ready(ok);
      if (ok) begin
         e = '{res: er, c: ec, z: ez, rd: rd, rd_val: erd, acc: cyc};
         sb.push_back(e);
         @(negedge clk);
         op_valid = 1'b0;
         check("ready_low_after_accept", 32'(op_ready), 32'd0);
      end
   endtask

   // Monitor: pops an expectation on every done pulse, then checks commit effects next cycle
   initial begin
      exp_t e;
      logic pend;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         if (pend) begin
            check("flag_carry", 32'(flag_carry), 32'(e.c));
            check("flag_zero", 32'(flag_zero), 32'(e.z));
            check("rd_value", 32'(dbg_data), 32'(e.rd_val));
            check("ready_back", 32'(op_ready), 32'd1);
            pend = 1'b0;
         end
         if (done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("done_latency", 32'(cyc), 32'(e.acc + 2));
               check("alu_result", 32'(alu_result), 32'(e.res));
               check("alu_cout", 32'(alu_cout), 32'(e.c));
               check("alu_zero", 32'(alu_zero), 32'(e.z));
               check("ready_low_at_done", 32'(op_ready), 32'd0);
               dbg_addr = e.rd;
               pend = 1'b1;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int accepts;
      logic ok;
      exp_t e;

      // Reset held for three edges
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_op_ready", 32'(op_ready), 32'd0);
         check("rst_alu_a", 32'(alu_a), 32'd0);
         check("rst_alu_b", 32'(alu_b), 32'd0);
         check("rst_alu_cin", 32'(alu_cin), 32'd0);
         check("rst_flags", {30'd0, flag_carry, flag_zero}, 32'd0);
         check("rst_done", 32'(done), 32'd0);
         check("rst_dbg_data", 32'(dbg_data), 32'd0);
      end
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 32'(op_ready), 32'd1);

      issue(0, 1, 1, 4'd1, 4'd0, 4'd0, 8'h05, 8'h05, 0, 0, 8'h05);
      issue(0, 0, 1, 4'd2, 4'd1, 4'd1, 8'h00, 8'h0A, 0, 0, 8'h0A);

      issue(0, 1, 1, 4'd3, 4'd0, 4'd0, 8'hFF, 8'hFF, 0, 0, 8'hFF);
      issue(0, 1, 1, 4'd3, 4'd3, 4'd0, 8'h01, 8'h00, 1, 1, 8'h00);

      issue(0, 1, 1, 4'd4, 4'd0, 4'd0, 8'h03, 8'h03, 0, 0, 8'h03);
      issue(0, 1, 1, 4'd5, 4'd0, 4'd0, 8'h05, 8'h05, 0, 0, 8'h05);
      issue(1, 0, 1, 4'd6, 4'd4, 4'd5, 8'h00, 8'hFE, 0, 0, 8'hFE);
      issue(1, 0, 1, 4'd7, 4'd5, 4'd5, 8'h00, 8'h00, 1, 1, 8'h00);

      issue(0, 1, 1, 4'd10, 4'd5, 4'd0, 8'h10, 8'h15, 0, 0, 8'h15);

      // Compare with op_valid held for 6 cycles: r5 - 0x05, rd r4 untouched
      accepts = 0;
      @(negedge clk);
      drive_op(1, 1, 0, 4'd4, 4'd5, 4'd0, 8'h05);
      for (int i = 0; i < 6; i++) begin
         if (i != 0) @(negedge clk);
         if (op_ready) begin
            accepts++;
            e = '{res: 8'h00, c: 1'b1, z: 1'b1, rd: 4'd4, rd_val: 8'h03, acc: cyc};
            sb.push_back(e);
         end
      end
      @(negedge clk);
      op_valid = 1'b0;
      check("held_valid_accepts", 32'(accepts), 32'd2);

      // Reset during S_EXEC aborts the op
      @(negedge clk);
      drive_op(0, 1, 1, 4'd8, 4'd0, 4'd0, 8'h11);
      wait_ready(ok);
      if (ok) begin
         @(negedge clk);
         op_valid = 1'b0;
         check("abort_operand_b", 32'(alu_b), 32'h11);
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         @(negedge clk);
         check("abort_ready", 32'(op_ready), 32'd1);
         check("abort_flags", {30'd0, flag_carry, flag_zero}, 32'd0);
         check("abort_alu_b", 32'(alu_b), 32'd0);
      end
      issue(0, 0, 1, 4'd9, 4'd8, 4'd2, 8'h00, 8'h00, 0, 1, 8'h00);

      repeat (6) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
